// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative signed multiply/divide unit.
package multdiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int ITERATIONS = 32;
  localparam int CNT_W      = 6;

  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/multdiv_if.sv
// Operand, strobe and result bundle between the execute stage and multdiv_seq.
interface multdiv_if;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  modport master (
    output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    input  data_result, data_exception, data_resultRDY
  );

  modport slave (
    input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    output data_result, data_exception, data_resultRDY
  );
endinterface

// File: rtl/multdiv_step.sv
// One combinational iteration: add-shift when mode_div=0, subtract-restore when mode_div=1.
module multdiv_step
  import multdiv_pkg::*;
(
  input  logic        mode_div,
  input  logic [63:0] acc_i,
  input  logic [63:0] mcand_i,
  input  logic [31:0] mplier_i,
  output logic [63:0] acc_o,
  output logic [63:0] mcand_o,
  output logic [31:0] mplier_o
);

  logic [63:0] shifted;
  logic [32:0] diff;

  always_comb begin
    acc_o    = acc_i;
    mcand_o  = mcand_i;
    mplier_o = mplier_i;
    shifted  = {acc_i[62:0], 1'b0};
    diff     = {1'b0, shifted[63:32]} - {1'b0, mcand_i[31:0]};
    if (mode_div) begin
      // acc holds {remainder, dividend-becoming-quotient}; a borrow means restore
      if (diff[32]) begin
        acc_o = shifted;
      end else begin
        acc_o = {diff[31:0], shifted[31:1], 1'b1};
      end
    end else begin
      acc_o    = mplier_i[0] ? (acc_i + mcand_i) : acc_i;
      mcand_o  = {mcand_i[62:0], 1'b0};
      mplier_o = {1'b0, mplier_i[31:1]};
    end
  end

endmodule

// File: rtl/multdiv_seq.sv
// Iterative signed 32-bit multiply/divide: 32 magnitude iterations plus a sign fix-up.
// Optional MULTDIV_EARLY_OUT_EN finishes divide-by-zero and zero-operand multiply at E1.
module multdiv_seq
  import multdiv_pkg::*;
(
  input logic      clock,
  input logic      reset,
  multdiv_if.slave bus
);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [63:0]       acc_q, acc_d;
  logic [63:0]       mcand_q, mcand_d;
  logic [31:0]       mplier_q, mplier_d;
  logic              sign_q, sign_d;
  logic [31:0]       result_q, result_d;
  logic              exc_q, exc_d;
  logic              rdy_q, rdy_d;

  logic [63:0]       acc_s, mcand_s;
  logic [31:0]       mplier_s;

  logic [63:0]       prod;
  logic [31:0]       quot;
  logic              mult_exc, div_zero, div_exc, early, busy, last, start;

  multdiv_step u_step (
    .mode_div (state_q == DIV),
    .acc_i    (acc_q),
    .mcand_i  (mcand_q),
    .mplier_i (mplier_q),
    .acc_o    (acc_s),
    .mcand_o  (mcand_s),
    .mplier_o (mplier_s)
  );

  // Final-iteration results, valid only when the last step is taken
  always_comb begin
    prod     = sign_q ? (~acc_s + 64'd1) : acc_s;
    mult_exc = !((&prod[63:31]) || !(|prod[63:31]));
    div_zero = (mcand_q[31:0] == 32'd0);
    quot     = div_zero ? 32'd0 : (sign_q ? (~acc_s[31:0] + 32'd1) : acc_s[31:0]);
    div_exc  = div_zero || (!sign_q && acc_s[31]);
    busy     = (state_q == MULT) || (state_q == DIV);
    last     = (cnt_q == CNT_W'(ITERATIONS - 1));
    start    = bus.ctrl_MULT || bus.ctrl_DIV;
`ifdef MULTDIV_EARLY_OUT_EN
    early = busy && (cnt_q == '0) &&
            ((state_q == DIV) ? div_zero : ((mcand_q == 64'd0) || (mplier_q == 32'd0)));
`else
    early = 1'b0;
`endif
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    sign_d   = sign_q;
    result_d = result_q;
    exc_d    = exc_q;
    rdy_d    = 1'b0;

    case (state_q)
      MULT, DIV: begin
        acc_d    = acc_s;
        mcand_d  = mcand_s;
        mplier_d = mplier_s;
        cnt_d    = cnt_q + 1'b1;
        if (early) begin
          result_d = 32'd0;
          exc_d    = (state_q == DIV);
          rdy_d    = 1'b1;
          state_d  = DONE;
        end else if (last) begin
          result_d = (state_q == DIV) ? quot : prod[31:0];
          exc_d    = (state_q == DIV) ? div_exc : mult_exc;
          rdy_d    = 1'b1;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A start overrides any in-flight work; a completion on this same edge still reports
    if (start) begin
      state_d  = bus.ctrl_MULT ? MULT : DIV;
      cnt_d    = '0;
      sign_d   = bus.data_operandA[31] ^ bus.data_operandB[31];
      mplier_d = abs32(bus.data_operandB);
      if (bus.ctrl_MULT) begin
        acc_d   = 64'd0;
        mcand_d = {32'd0, abs32(bus.data_operandA)};
      end else begin
        acc_d   = {32'd0, abs32(bus.data_operandA)};
        mcand_d = {32'd0, abs32(bus.data_operandB)};
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= 64'd0;
      mcand_q  <= 64'd0;
      mplier_q <= 32'd0;
      sign_q   <= 1'b0;
      result_q <= 32'd0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      sign_q   <= sign_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
    end
  end

  assign bus.data_result    = result_q;
  assign bus.data_exception = exc_q;
  assign bus.data_resultRDY = rdy_q;

endmodule

// File: doc/multdiv_seq.md
# multdiv_seq

Iterative signed 32-bit multiply/divide unit for the pipelined processor's execute stage. The execute stage feeds it operands and a one-cycle start strobe. It stalls the pipeline until the unit pulses ready, then latches the result and the exception flag into the X/M latch. Multiply is shift-add and divide is restoring; each runs on operand magnitudes with a sign fix-up at the end.

## Interface
- No parameters; widths are fixed by the ISA (32-bit operands, 32 iterations).
- clock  in  1  master clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; forces IDLE and clears all outputs.
- data_operandA  in  32  multiplicand / dividend (two's complement); sampled only on a start edge.
- data_operandB  in  32  multiplier / divisor (two's complement); sampled only on a start edge.
- ctrl_MULT  in  1  start multiply; single-cycle strobe.
- ctrl_DIV  in  1  start divide; single-cycle strobe.
- data_result  out  32  low 32 bits of the product, or the quotient; registered.
- data_exception  out  1  overflow or divide-by-zero flag; registered; meaningful only with or after data_resultRDY.
- data_resultRDY  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, MULT, DIV, DONE. A 6-bit iteration counter is held in a register.
- Start is a rising edge with ctrl_MULT or ctrl_DIV high (edge E0). At E0:
  - capture |A| and |B| and the result sign (A[31]^B[31]);
  - clear the accumulator/remainder;
  - set counter = 0;
  - go to MULT or DIV.
- If ctrl_MULT and ctrl_DIV are high together, MULT wins.
- MULT: each edge adds the shifted multiplicand to the 64-bit accumulator if the current multiplier bit is 1, then shifts.
- DIV: each edge shifts the remainder left, subtracts the divisor, and restores it if the result is negative; the quotient bit is 1 otherwise.
- After 32 iterations, move to DONE:
  - negate the magnitude result if the sign is 1;
  - register data_result and data_exception;
  - assert data_resultRDY.
- DONE always moves to IDLE on the next edge. data_result and data_exception then hold until the next start or reset.
- Multiply exception: the signed 64-bit product does not fit in 32 bits, i.e. bits [63:31] are not all equal. data_result is still the low 32 bits.
- Divide: quotient truncates toward zero. The remainder is discarded.
- Divide by zero: data_result = 0, data_exception = 1.
- 0x80000000 / 0xFFFFFFFF: data_result = 0x80000000, data_exception = 1.
- A start while in MULT, DIV or DONE aborts the current operation and restarts from E0 with the new operands. The aborted operation never produces a ready pulse.
- ctrl_* high in any cycle other than a start edge has no further effect. The caller pulses them once.

## Timing
- Reset values:
  - data_result = 0, data_exception = 0, data_resultRDY = 0;
  - state IDLE, counter 0.
- Reset mid-operation: outputs go to zero immediately (asynchronous); the in-flight operation is lost.
- Latency: iteration edges are E1..E32. data_resultRDY is high from E32 to E33, exactly one cycle. data_result is valid in that same cycle.
- No back-to-back overlap: a start edge at E32 is legal. It restarts, the result pulse still occurs at E32, and the next pulse is at E32+32.
- No combinational path from inputs to outputs.

## Configuration
- MULTDIV_EARLY_OUT_EN defined:
  - divide-by-zero completes at E1 (ready high E1..E2, result 0, exception 1);
  - a multiply with either operand zero completes at E1 with result 0, exception 0;
  - all other operations keep 32-cycle latency.
- Undefined: every operation takes exactly 32 cycles regardless of operands. Divide-by-zero still yields result 0, exception 1 at E32.

## Structure
- Shared package multdiv_pkg holds:
  - state encoding (IDLE=2'd0, MULT=2'd1, DIV=2'd2, DONE=2'd3);
  - ITERATIONS = 32;
  - CNT_W = 6.
- One sub-module, multdiv_step: the combinational single-iteration datapath (add-shift for MULT, subtract-restore for DIV), selected by a mode bit. multdiv_seq owns the FSM, counter, operand/sign registers and output registers.

## Test plan
- Multiply 7 × -3 (0xFFFFFFFD) -> ready pulse only in the E32 cycle, result 0xFFFFFFEB, exception 0.
- Multiply 0x00010000 × 0x00010000 -> result 0x00000000, exception 1; also 0x40000000 × 2 -> result 0x80000000, exception 1.
- Divide -7 / 2 -> result 0xFFFFFFFD (-3), exception 0; also 0x80000000 / -1 -> 0x80000000, exception 1.
- Divide 5 / 0 -> result 0, exception 1: at E32 without MULTDIV_EARLY_OUT_EN, at E1 with it; repeat with multiply 0 × 123 (E1 only when the macro is defined).
- Start multiply 3 × 4, then start divide 100 / 7 at E10 -> no pulse at E32 of the multiply; a single pulse 32 edges after E10 with result 14, exception 0.
- Assert reset at E15 of a multiply -> outputs 0 immediately, no ready pulse. A new multiply 6 × 6 after reset release -> result 36 at its own E32.
